// File: rtl/time_keeper.sv
// 24-hour BCD real-time clock with debounced hour/minute set buttons.
// Feeds the LCD driver digits plus a one-cycle refresh strobe.
module time_keeper #(
    parameter int CLOCK_RATE      = 1000,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hour_inc,
    input  logic       min_inc,
    output logic [1:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       update
);

    localparam int PW = $clog2(CLOCK_RATE);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_RATE - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the hour button, index 1 the minute button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [1:0]    press;
    logic [CW-1:0] cnt [2];

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic [5:0]    hrs;
    logic [5:0]    hrs_n;
    logic [6:0]    mins;
    logic [6:0]    mins_n;
    logic [6:0]    secs;
    logic [6:0]    secs_n;
    logic          tick;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hour_carry;
    logic          changed;

    assign raw = {min_inc, hour_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_d  <= '0;
            press  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    function automatic logic [6:0] step60(input logic [6:0] v);
        if (v == 7'h59)
            return 7'h00;
        else if (v[3:0] == 4'd9)
            return {v[6:4] + 3'd1, 4'd0};
        else
            return {v[6:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [5:0] step24(input logic [5:0] v);
        if (v == 6'h23)
            return 6'h00;
        else if (v[3:0] == 4'd9)
            return {v[5:4] + 2'd1, 4'd0};
        else
            return {v[5:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        tick       = (presc == PRESC_MAX);
        sec_wrap   = (secs == 7'h59);
        min_wrap   = (mins == 7'h59);
        presc_n    = presc + 1'b1;
        secs_n     = secs;
        mins_n     = mins;
        hrs_n      = hrs;
        hour_carry = 1'b0;
        // A minute press resynchronises the second boundary and wins over a tick.
        if (press[1]) begin
            presc_n = '0;
            secs_n  = '0;
            mins_n  = step60(mins);
        end else if (tick) begin
            presc_n = '0;
            secs_n  = step60(secs);
            if (sec_wrap) begin
                mins_n     = step60(mins);
                hour_carry = min_wrap;
            end
        end
        if (hour_carry)
            hrs_n = step24(hrs_n);
        if (press[0])
            hrs_n = step24(hrs_n);
        changed = ({hrs_n, mins_n, secs_n} != {hrs, mins, secs});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc  <= '0;
            hrs    <= '0;
            mins   <= '0;
            secs   <= '0;
            update <= 1'b0;
        end else begin
            presc  <= presc_n;
            hrs    <= hrs_n;
            mins   <= mins_n;
            secs   <= secs_n;
            update <= changed;
        end
    end

    assign hour_tens = hrs[5:4];
    assign hour_ones = hrs[3:0];
    assign min_tens  = mins[6:4];
    assign min_ones  = mins[3:0];
    assign sec_tens  = secs[6:4];
    assign sec_ones  = secs[3:0];

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: scheduled expectations in a queue, checked
// at the falling edge once the cycle counter reaches their due cycle.
module tb_time_keeper;

    localparam int CR = 10;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hour_inc = 1'b0;
    logic       min_inc = 1'b0;
    logic [1:0] hour_tens;
    logic [3:0] hour_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       update;

    always #5 clk = ~clk;

    time_keeper #(
        .CLOCK_RATE     (CR),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .hour_inc (hour_inc),
        .min_inc  (min_inc),
        .hour_tens(hour_tens),
        .hour_ones(hour_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .update   (update)
    );

    typedef struct {
        int          at;
        logic [23:0] t;
        int          upd;
        string       name;
    } exp_t;

    typedef struct {
        int          at;
        logic [23:0] t;
        int          upd;
    } vec_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          upd_cnt = 0;
    logic [23:0] now_t;

    assign now_t = {2'b00, hour_tens, hour_ones, 1'b0, min_tens, min_ones,
                    1'b0, sec_tens, sec_ones};

    always @(posedge clk or posedge reset) begin
        if (reset)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [23:0] act,
                       input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: time got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && update === 1'b1)
            upd_cnt++;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at != cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: checked at cycle %0d expected cycle %0d",
                         e.name, cyc, e.at);
            end else begin
                chk(e.name, now_t, e.t);
                if (e.upd >= 0)
                    chkn({e.name, "_upd"}, int'(update), e.upd);
            end
        end
    end

    task automatic expect_at(input int at, input logic [23:0] t,
                             input int upd, input string name);
        exp_t e;
        e.at   = at;
        e.t    = t;
        e.upd  = upd;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic flush();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: not reached, now cycle %0d expected cycle %0d",
                     e.name, cyc, e.at);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k)
            @(negedge clk);
    endtask

    task automatic do_reset(input logic hold_min);
        flush();
        hour_inc = 1'b0;
        min_inc  = hold_min;
        reset    = 1'b1;
        step(2);
        chk("reset_state", now_t, 24'h000000);
        chkn("reset_update", int'(update), 0);
        reset = 1'b0;
    endtask

    task automatic press(input int b);
        if (b == 0)
            hour_inc = 1'b1;
        else
            min_inc = 1'b1;
        step(10);
        hour_inc = 1'b0;
        min_inc  = 1'b0;
        step(10);
    endtask

    task automatic build(input int h);
        for (int i = 0; i < h; i++)
            press(0);
        for (int i = 0; i < 59; i++)
            press(1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl[7];
        int   u0;

        // Free running from reset.
        tbl = '{'{9, 24'h000000, 0}, '{10, 24'h000001, 1},
                '{11, 24'h000001, 0}, '{99, 24'h000009, -1},
                '{100, 24'h000010, 1}, '{599, 24'h000059, -1},
                '{600, 24'h000100, 1}};
        do_reset(1'b0);
        u0 = upd_cnt;
        foreach (tbl[i])
            expect_at(tbl[i].at, tbl[i].t, tbl[i].upd,
                      $sformatf("idle_c%0d", tbl[i].at));
        wait_cyc(601);
        chkn("idle_update_count", upd_cnt - u0, 60);

        // Set to 23:59 by buttons, then run through midnight.
        do_reset(1'b0);
        expect_at(8, 24'h010000, 1, "set_first_hour");
        expect_at(460, 24'h230046, -1, "set_hours_done");
        expect_at(1628, 24'h235900, 1, "set_last_min");
        expect_at(1640, 24'h235901, -1, "set_done");
        expect_at(2227, 24'h235959, -1, "pre_midnight");
        expect_at(2228, 24'h000000, 1, "midnight");
        build(23);
        wait_cyc(1641);
        u0 = upd_cnt;
        wait_cyc(2229);
        chkn("wrap_update_count", upd_cnt - u0, 59);

        // Bounce rejection, then one press for a long hold.
        do_reset(1'b0);
        u0 = upd_cnt;
        expect_at(9, 24'h000000, 0, "bounce_quiet");
        expect_at(20, 24'h000002, 1, "bounce_after");
        expect_at(28, 24'h000002, -1, "hold_before");
        expect_at(29, 24'h010002, 1, "hold_edge7");
        expect_at(30, 24'h010003, 1, "hold_tick");
        expect_at(60, 24'h010006, 1, "hold_no_repeat");
        hour_inc = 1'b1;
        wait_cyc(3);
        hour_inc = 1'b0;
        wait_cyc(5);
        hour_inc = 1'b1;
        wait_cyc(8);
        hour_inc = 1'b0;
        wait_cyc(21);
        chkn("bounce_update_count", upd_cnt - u0, 2);
        u0 = upd_cnt;
        hour_inc = 1'b1;
        wait_cyc(41);
        hour_inc = 1'b0;
        wait_cyc(61);
        chkn("hold_update_count", upd_cnt - u0, 5);

        // Minute press at 05:59:37, then one landing on a tick.
        do_reset(1'b0);
        expect_at(100, 24'h050010, -1, "m_hours_done");
        expect_at(1268, 24'h055900, 1, "m_last_min");
        expect_at(1280, 24'h055901, -1, "m_set_done");
        expect_at(1638, 24'h055937, 1, "m_at_37");
        expect_at(1645, 24'h055937, -1, "m_before_press");
        expect_at(1646, 24'h050000, 1, "m_press_wrap");
        expect_at(1655, 24'h050000, -1, "m_presc_restart");
        expect_at(1656, 24'h050001, 1, "m_first_tick");
        expect_at(1675, 24'h050002, -1, "m_before_align");
        expect_at(1676, 24'h050100, 1, "m_press_on_tick");
        expect_at(1685, 24'h050100, -1, "m_after_align");
        expect_at(1686, 24'h050101, 1, "m_next_tick");
        build(5);
        wait_cyc(1638);
        min_inc = 1'b1;
        wait_cyc(1648);
        min_inc = 1'b0;
        wait_cyc(1668);
        min_inc = 1'b1;
        wait_cyc(1678);
        min_inc = 1'b0;
        wait_cyc(1687);

        // Hour press coincident with the carry into hours.
        do_reset(1'b0);
        expect_at(440, 24'h220044, -1, "h22_hours_done");
        expect_at(1620, 24'h225901, -1, "h22_set_done");
        expect_at(2207, 24'h225959, -1, "h22_before");
        expect_at(2208, 24'h000000, 1, "h22_double");
        expect_at(2230, 24'h000002, -1, "h22_after");
        build(22);
        wait_cyc(2200);
        hour_inc = 1'b1;
        wait_cyc(2210);
        hour_inc = 1'b0;
        wait_cyc(2231);

        do_reset(1'b0);
        expect_at(1640, 24'h235901, -1, "h23_set_done");
        expect_at(2227, 24'h235959, -1, "h23_before");
        expect_at(2228, 24'h010000, 1, "h23_double");
        build(23);
        wait_cyc(2220);
        hour_inc = 1'b1;
        wait_cyc(2230);
        hour_inc = 1'b0;
        wait_cyc(2231);

        // Asynchronous reset during a minute debounce.
        do_reset(1'b0);
        expect_at(70, 24'h000007, 1, "ar_at_7");
        wait_cyc(66);
        min_inc = 1'b1;
        wait_cyc(70);
        #2;
        reset   = 1'b1;
        min_inc = 1'b0;
        #1;
        chk("async_digits", now_t, 24'h000000);
        chkn("async_update", int'(update), 0);
        step(2);
        reset = 1'b0;
        u0 = upd_cnt;
        expect_at(9, 24'h000000, 0, "ar_quiet");
        expect_at(10, 24'h000001, 1, "ar_first_tick");
        wait_cyc(12);
        chkn("ar_update_count", upd_cnt - u0, 1);

        // Minute button held through reset release.
        do_reset(1'b1);
        expect_at(7, 24'h000000, 0, "held_before");
        expect_at(8, 24'h000100, 1, "held_press");
        expect_at(18, 24'h000101, 1, "held_tick");
        wait_cyc(10);
        min_inc = 1'b0;
        wait_cyc(19);

        flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
